// File: rtl/apb_cmd_master.sv
// apb_cmd_master: APB3 master fed by a small command FIFO.
// Each queued command becomes one APB transfer (SETUP, then ACCESS), and
// each transfer returns one response. Responses come back in command order.
// Optional build macro: APB_CMD_MASTER_TIMEOUT_EN. When it is defined, a
// watchdog ends any ACCESS phase that sees TIMEOUT cycles with PREADY low,
// and that response is returned with rsp_err set.
module apb_cmd_master #(
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  // command side
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADR_W-1:0] cmd_addr,
  input  logic [DAT_W-1:0] cmd_wdata,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_rdata,
  output logic             rsp_err,
  // APB3 master port
  output logic [ADR_W-1:0] PADDR,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [DAT_W-1:0] PWDATA,
  input  logic             PREADY,
  input  logic [DAT_W-1:0] PRDATA,
  input  logic             PSLVERR
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADR_W + DAT_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  // The watchdog counter is 16 bits wide, so TIMEOUT must lie in 1..65535.
  // An out-of-range value selects this empty block and changes nothing else.
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_timeout_out_of_range
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q [CMD_DEPTH];
  logic [ENT_W-1:0] mem_d [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;

  // FSM and APB outputs
  state_e           state_q, state_d;
  logic [ADR_W-1:0] paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [DAT_W-1:0] pwdata_q, pwdata_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;

  // Response registers
  logic             rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  // Handshake and FIFO head decode
  logic             push_s;
  logic             pop_s;
  logic             not_empty_s;
  logic [ENT_W-1:0] head_s;
  logic             head_write_s;
  logic [ADR_W-1:0] head_addr_s;
  logic [DAT_W-1:0] head_wdata_s;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
`endif

  assign not_empty_s  = (count_q != ZERO_CNT);
  assign head_s       = mem_q[rd_ptr_q];
  assign head_write_s = head_s[ENT_W-1];
  assign head_addr_s  = head_s[ADR_W+DAT_W-1 -: ADR_W];
  assign head_wdata_s = head_s[DAT_W-1:0];

  // FIFO next state: push on handshake, pop when the FSM takes the head.
  always_comb begin
    push_s   = cmd_valid & cmd_ready_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_wdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Ready follows the count only, so a full FIFO stays not-ready even when
    // a pop happens in the same cycle.
    cmd_ready_d = (count_d != FULL_CNT);
  end

  // APB transfer sequencing, head pop and response capture.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (not_empty_s) begin
          pop_s    = 1'b1;
          paddr_d  = head_addr_s;
          pwrite_d = head_write_s;
          pwdata_d = head_wdata_s;
          state_d  = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        wd_cnt_d = 16'd0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rsp_err_d = PSLVERR;
          // Writes and errored reads return zero data.
          if (pwrite_q || PSLVERR) begin
            rsp_rdata_d = {DAT_W{1'b0}};
          end else begin
            rsp_rdata_d = PRDATA;
          end
          state_d = ST_RESP;
        end else begin
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + 16'd1;
          // Counter reaches TIMEOUT at this edge: abandon the transfer.
          if (wd_cnt_q == WD_LAST) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = {DAT_W{1'b0}};
            state_d     = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (not_empty_s) begin
            // Chain straight into the next transfer without an IDLE cycle.
            pop_s    = 1'b1;
            paddr_d  = head_addr_s;
            pwrite_d = head_write_s;
            pwdata_d = head_wdata_s;
            state_d  = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Bus and response strobes decode the next state so they are registered.
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // FIFO registers; reset discards every queued command.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= ZERO_CNT;
      cmd_ready_q <= 1'b1;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // FSM, APB and response registers; reset drops PSEL/PENABLE at once.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= {ADR_W{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {DAT_W{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DAT_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  // Watchdog counter of ACCESS cycles spent waiting on PREADY.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wd_cnt_q <= 16'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
